// File: rtl/mult_booth_seq.sv
// Sequential signed radix-2 Booth multiplier: one Booth step per clock, full-width
// product written to hi/lo together with a one-cycle done pulse.
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic             qm1_d;

    // One Booth step: conditional add/sub of the widened multiplicand, then arithmetic shift
    always_comb begin
        m_ext_s = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   sum_s = acc_q + m_ext_s;
            2'b10:   sum_s = acc_q - m_ext_s;
            default: sum_s = acc_q;
        endcase
        acc_d = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_d   = {sum_s[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
    end

    // Control FSM and datapath registers; hi/lo only change on the final step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= A;
                        q_q     <= B;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= acc_d[WIDTH-1:0];
                        lo_q    <= q_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq: directed corner cases plus random operands
// compared against a plain signed-multiply reference.
module tb_mult_booth_seq;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;

    int            total;
    int            bad;
    logic [63:0]   prev;
    int            poke_at;
    int            rst_at;
    bit            chain;
    bit            skip;
    logic [W-1:0]  na;
    logic [W-1:0]  nb;

    mult_booth_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] expv;
        int          e;
        int          extra_done;
        bit          busy_ok;
        bit          aborted;
        expv    = ref_mul(a, b);
        busy_ok = 1'b1;
        aborted = 1'b0;
        if (!skip) begin
            @(negedge clk);
            A     = a;
            B     = b;
            start = 1'b1;
        end
        skip = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        e     = 0;
        while (!done && e < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (e == W / 2) check_eq("hold_prev", {hi, lo}, prev);
            if (e == rst_at) begin
                reset = 1'b0;
                #1;
                check_eq("abort_hilo", {hi, lo}, 64'd0);
                check_eq("abort_flags", {62'd0, busy, done}, 64'd0);
                aborted = 1'b1;
                break;
            end
            start = (e == poke_at);
            if (start) begin
                A = $urandom;
                B = $urandom;
            end
            @(negedge clk);
            e++;
        end
        if (aborted) begin
            @(negedge clk);
            reset      = 1'b1;
            rst_at     = -1;
            extra_done = 0;
            repeat (40) begin
                @(negedge clk);
                if (done === 1'b1) extra_done++;
            end
            check_eq("no_done_after_abort", 64'(extra_done), 64'd0);
            prev = 64'd0;
        end else begin
            check_eq("latency", 64'(e), 64'(W));
            check_eq("busy_during_run", 64'(busy_ok), 64'd1);
            check_eq("busy_at_done", 64'(busy), 64'd0);
            check_eq("product", {hi, lo}, expv);
            prev    = expv;
            poke_at = -1;
            if (chain) begin
                A     = na;
                B     = nb;
                start = 1'b1;
                chain = 1'b0;
                skip  = 1'b1;
            end else begin
                @(negedge clk);
                start = 1'b0;
                check_eq("done_one_cycle", 64'(done), 64'd0);
                check_eq("hold_after_done", {hi, lo}, expv);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        prev    = 64'd0;
        poke_at = -1;
        rst_at  = -1;
        chain   = 1'b0;
        skip    = 1'b0;
        na      = '0;
        nb      = '0;
        reset   = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_mul(32'd3, 32'd5);
        check_eq("small_const", {hi, lo}, 64'h0000_0000_0000_000F);
        do_mul(32'hFFFF_FFF9, 32'd6);
        check_eq("neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        do_mul(32'h8000_0000, 32'h8000_0000);
        check_eq("minmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
        do_mul(32'h8000_0000, 32'd1);
        check_eq("min_one_const", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
        do_mul(32'h7FFF_FFFF, 32'h8000_0000);
        do_mul(32'd0, 32'hDEAD_BEEF);

        // start re-asserted mid-run must be ignored
        poke_at = 10;
        do_mul($urandom, $urandom);

        // reset in the middle aborts; next operation is normal
        rst_at = W / 2;
        do_mul(32'd1234, 32'd5678);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // back-to-back: start held through the done cycle
        na    = 32'hFFFF_0001;
        nb    = 32'h0001_FFFF;
        chain = 1'b1;
        do_mul(32'd77, 32'hFFFF_FF00);
        do_mul(na, nb);

        for (int i = 0; i < 16; i++) begin
            do_mul($urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
